result_display_scanner: RTL and testbench
=========================================

# result_display_scanner

Downstream observer of the 5-stage pipeline core. It watches the core's `v0`/`v1` result outputs and queues each change in a small FIFO. Each queued pair is shown for a fixed dwell time on an 8-digit multiplexed seven-segment display, so results the core produces faster than a human can read are not lost. It sits beside the core in the board top level and feeds the display pins directly.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `DWELL`, 100000000: clock cycles each popped entry is held on the display; ≥2.
- `REFRESH`, 100000: clock cycles each digit is lit per scan step; ≥1.
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-low reset.
- `v0`  in  32  core result register; bits [15:0] are displayed on the left half.
- `v1`  in  32  core result register; bits [15:0] are displayed on the right half.
- `Pending`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `Full`  out  1  asserted when `Pending == DEPTH`.
- `Overflow`  out  1  sticky; set when a change is dropped; cleared only by reset.
- `an`  out  8  active-low digit enables; bit 7 is the leftmost digit.
- `seg`  out  7  active-low segments `{g,f,e,d,c,b,a}`.

## Operation
- **Capture**
  - `last_v0` and `last_v1` register `v0`/`v1` every cycle.
  - A change is any cycle where `{v0[15:0],v1[15:0]} != {last_v0[15:0],last_v1[15:0]}`.
  - On a change, push `{v0[15:0],v1[15:0]}` into the FIFO.
  - If the FIFO is full and no pop occurs that cycle, drop the entry and set `Overflow`.
  - A push and a pop in the same cycle while full: the push is accepted and `Pending` stays at `DEPTH`.
- **FSM**
  - States `IDLE` and `SHOW`; a 32-bit `hold` register, a dwell counter `dcnt`, and read/write pointers that wrap modulo `DEPTH`.
  - `IDLE`: if the FIFO is non-empty, pop the head into `hold`, set `dcnt=0`, go to `SHOW`.
  - `SHOW`: increment `dcnt`. When `dcnt == DWELL-1`:
    - FIFO non-empty: pop into `hold`, set `dcnt=0`, stay in `SHOW`.
    - FIFO empty: go to `IDLE`; `hold` keeps its value.
- **Scan**
  - `rcnt` counts 0..`REFRESH-1`. On wrap, the digit index `dig` increments 0..7 and wraps to 0.
  - `an` = all ones except bit `dig` low.
  - Digit `d` shows nibble `hold[4d+3:4d]`. Digit 7 is `v0[15:12]`; digit 0 is `v1[3:0]`.
  - Hex font, active low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.

## Timing
- Reset values (applied while `Reset` is low at the edge):
  - `an=8'hFF`, `seg=7'h7F`, `Pending=0`, `Full=0`, `Overflow=0`.
  - state `IDLE`; `hold`, `dcnt`, `rcnt`, `dig`, pointers, `last_v0`, `last_v1` all 0.
- Reset asserted mid-`SHOW` aborts immediately and discards all FIFO contents.
- Because `last_v*` reset to 0, nonzero inputs present at reset release count as a change in the first cycle after release.
- Push latency: a change sampled at edge N is written at edge N; `Pending` reflects it in cycle N+1.
- Pop latency:
  - The `IDLE` pop happens at edge N+1; `hold` is valid in cycle N+2.
  - `an`/`seg` are registered from `hold`/`dig`, so the display reflects `hold` one cycle later (N+3).
- Successive pops while entries are waiting are exactly `DWELL` cycles apart.
- `an`/`seg` update one cycle after `dig` or `hold` changes. First cycle after reset release: `an=FE`, `seg=40`.

## Configuration
- `RESULT_BLANK_LEADING_EN` defined:
  - In each 4-digit half (digits 7..4 and 3..0), zero digits to the left of the half's first nonzero digit output `seg=7'h7F`. `an` is still driven normally.
  - Digits 4 and 0 are never blanked.
- Not defined: all eight digits always show their hex value.

## Test plan
Parameters: `DEPTH=4`, `DWELL=8`, `REFRESH=2`.
- Reset: hold `Reset=0` for 3 cycles with `v0=v1=0` -> `an=FF`, `seg=7F`, `Pending=0`, `Overflow=0`. Release -> next cycle `an=FE`, `seg=40`; `dig` advances every 2 cycles.
- Single result: `v0=0x1234`, `v1=0` at cycle N -> `Pending=1` in cycle N+1, 0 in N+2. `hold=0x12340000` in N+2. When `dig=7`: `an=7F`, `seg=79`.
- Overflow: 6 distinct `v0` values on consecutive cycles starting from `IDLE` -> one pop, 4 queued, `Full=1`, sixth value dropped, `Overflow=1`. `Overflow` stays 1 after the FIFO drains.
- Dwell: two changes 1 cycle apart -> `hold` takes the first value, then the second exactly 8 cycles later. FSM returns to `IDLE` 8 cycles after that, with `hold` retaining the second value.
- Blanking: `v0=0x0007`, `v1=0`.
  - With the macro: digits 7..5 and 3..1 show `seg=7F`, digit 4 shows `78`, digit 0 shows `40`.
  - Without the macro: digit 7 shows `40`.
- Reset mid-`SHOW` with 3 entries queued and `v0=0x00AB` held steady -> after release `Pending` becomes 1 (re-capture of `0x00AB0000`). The FIFO holds no older entries.

Source files
------------

// File: rtl/result_display_scanner.sv
// result_display_scanner: queues changes of the core's v0/v1 results in a FIFO.
// It holds each queued pair on an 8-digit multiplexed seven-segment display.
//
// Parameters:
//   DEPTH   FIFO entries (power of two, >= 2)
//   DWELL   cycles each popped entry is held on the display (>= 2)
//   REFRESH cycles each digit is lit per scan step (>= 1)
// Ports:
//   Clk       single clock, rising edge
//   Reset     synchronous, active-low reset
//   v0, v1    core results; the low 16 bits of each are shown (v0 on the left half)
//   Pending   FIFO occupancy
//   Full      Pending == DEPTH
//   Overflow  sticky flag, set when a change is dropped; cleared only by reset
//   an        active-low digit enables; bit 7 is the leftmost digit
//   seg       active-low segments {g,f,e,d,c,b,a}
// Optional feature:
//   RESULT_BLANK_LEADING_EN  blanks leading zeros within each 4-digit half
module result_display_scanner #(
    parameter int DEPTH   = 4,
    parameter int DWELL   = 100000000,
    parameter int REFRESH = 100000
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [31:0]             v0,
    input  logic [31:0]             v1,
    output logic [$clog2(DEPTH):0]  Pending,
    output logic                    Full,
    output logic                    Overflow,
    output logic [7:0]              an,
    output logic [6:0]              seg
);

    localparam int AW    = $clog2(DEPTH);
    localparam int DW    = $clog2(DWELL);
    localparam int RW    = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int DLAST = DWELL - 1;
    localparam int RLAST = REFRESH - 1;

    localparam logic [AW:0]   CNT_FULL  = DEPTH[AW:0];
    localparam logic [DW-1:0] DCNT_LAST = DLAST[DW-1:0];
    localparam logic [RW-1:0] RCNT_LAST = RLAST[RW-1:0];

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    // Capture / FIFO state
    logic [15:0]   last_v0_q;
    logic [15:0]   last_v1_q;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          ovf_q;

    // Display FSM state
    state_e        state_q, state_d;
    logic [31:0]   hold_q, hold_d;
    logic [DW-1:0] dcnt_q, dcnt_d;

    // Scan state
    logic [RW-1:0] rcnt_q;
    logic [2:0]    dig_q;
    logic [7:0]    an_q;
    logic [6:0]    seg_q;

    logic [31:0]   cur;
    logic          change;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [3:0]    nib;
    logic [7:0]    blank;
    logic          unused_hi;

    // Only the low halves of the results are displayed.
    assign unused_hi = ^{v0[31:16], v1[31:16]};

    assign cur    = {v0[15:0], v1[15:0]};
    assign change = (cur != {last_v0_q, last_v1_q});
    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CNT_FULL);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = change && (!full || pop);
    assign drop = change && full && !pop;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            last_v0_q <= '0;
            last_v1_q <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            last_v0_q <= v0[15:0];
            last_v1_q <= v1[15:0];
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset; occupancy tracks validity.
    always_ff @(posedge Clk) begin
        if (Reset && push) begin
            mem_q[wptr_q] <= cur;
        end
    end

    // FSM: state register
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (dcnt_q == DCNT_LAST && empty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs (pop, hold and dwell counter updates)
    always_comb begin
        pop    = 1'b0;
        hold_d = hold_q;
        dcnt_d = dcnt_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop    = 1'b1;
                    hold_d = mem_q[rptr_q];
                    dcnt_d = '0;
                end
            end
            SHOW: begin
                if (dcnt_q == DCNT_LAST) begin
                    dcnt_d = '0;
                    if (!empty) begin
                        pop    = 1'b1;
                        hold_d = mem_q[rptr_q];
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                pop = 1'b0;
            end
        endcase
    end

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign nib = hold_q[{dig_q, 2'b00} +: 4];

`ifdef RESULT_BLANK_LEADING_EN
    logic [7:0] zero;

    always_comb begin
        zero = '0;
        for (int i = 0; i < 8; i++) begin
            zero[i] = (hold_q[4*i +: 4] == 4'h0);
        end
    end

    // A digit blanks only if it and every digit left of it in its half are zero;
    // the rightmost digit of each half always shows.
    assign blank = {
        zero[7], &zero[7:6], &zero[7:5], 1'b0,
        zero[3], &zero[3:2], &zero[3:1], 1'b0
    };
`else
    assign blank = 8'h00;
`endif

    // Scan: digit index advances once per REFRESH cycles.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rcnt_q <= '0;
            dig_q  <= '0;
            an_q   <= 8'hFF;
            seg_q  <= 7'h7F;
        end else begin
            if (rcnt_q == RCNT_LAST) begin
                rcnt_q <= '0;
                dig_q  <= dig_q + 1'b1;
            end else begin
                rcnt_q <= rcnt_q + 1'b1;
            end
            an_q  <= ~(8'd1 << dig_q);
            seg_q <= blank[dig_q] ? 7'h7F : hex7(nib);
        end
    end

    assign Pending  = cnt_q;
    assign Full     = full;
    assign Overflow = ovf_q;
    assign an       = an_q;
    assign seg      = seg_q;

endmodule

// File: tb/tb_result_display_scanner.sv
// tb_result_display_scanner: directed self-checking bench for result_display_scanner.
// Runs with DEPTH=4, DWELL=8, REFRESH=2; every expectation is hand-computed.
module tb_result_display_scanner;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] v0 = '0;
    logic [31:0] v1 = '0;
    logic [2:0]  Pending;
    logic        Full;
    logic        Overflow;
    logic [7:0]  an;
    logic [6:0]  seg;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 Clk = ~Clk;

    result_display_scanner #(
        .DEPTH  (4),
        .DWELL  (8),
        .REFRESH(2)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .v0      (v0),
        .v1      (v1),
        .Pending (Pending),
        .Full    (Full),
        .Overflow(Overflow),
        .an      (an),
        .seg     (seg)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((dut.state_q !== 1'b0 || Pending !== 3'd0) && k < 100) begin
            tick();
            k++;
        end
        n_checks++;
        if (k >= 100) $display("FAIL %s_idle_timeout state=%b pending=%0d", tag, dut.state_q, Pending);
        else n_pass++;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        v0 = '0;
        v1 = '0;
        ticks(3);
        n_checks++;
        if (an !== 8'hFF) $display("FAIL rst_an got=%h want=%h", an, 8'hFF); else n_pass++;
        n_checks++;
        if (seg !== 7'h7F) $display("FAIL rst_seg got=%h want=%h", seg, 7'h7F); else n_pass++;
        n_checks++;
        if (Pending !== 3'd0) $display("FAIL rst_pending got=%0d want=0", Pending); else n_pass++;
        n_checks++;
        if (Full !== 1'b0) $display("FAIL rst_full got=%b want=0", Full); else n_pass++;
        n_checks++;
        if (Overflow !== 1'b0) $display("FAIL rst_ovf got=%b want=0", Overflow); else n_pass++;
        Reset = 1'b1;
        tick();
        n_checks++;
        if (an !== 8'hFE) $display("FAIL rel_an got=%h want=%h", an, 8'hFE); else n_pass++;
        n_checks++;
        if (seg !== 7'h40) $display("FAIL rel_seg got=%h want=%h", seg, 7'h40); else n_pass++;
        ticks(2);
        n_checks++;
        if (an !== 8'hFD) $display("FAIL scan_d1 got=%h want=%h", an, 8'hFD); else n_pass++;
        ticks(2);
        n_checks++;
        if (an !== 8'hFB) $display("FAIL scan_d2 got=%h want=%h", an, 8'hFB); else n_pass++;
    endtask

    task automatic test_single();
        int k;
        wait_idle("single");
        v0 = 32'h0000_1234;
        v1 = '0;
        tick();
        n_checks++;
        if (Pending !== 3'd1) $display("FAIL single_pend1 got=%0d want=1", Pending); else n_pass++;
        tick();
        n_checks++;
        if (Pending !== 3'd0) $display("FAIL single_pend0 got=%0d want=0", Pending); else n_pass++;
        n_checks++;
        if (dut.hold_q !== 32'h1234_0000)
            $display("FAIL single_hold got=%h want=%h", dut.hold_q, 32'h1234_0000);
        else n_pass++;
        tick();
        k = 0;
        while (an !== 8'h7F && k < 20) begin
            tick();
            k++;
        end
        n_checks++;
        if (an !== 8'h7F || seg !== 7'h79)
            $display("FAIL single_dig7 an=%h seg=%h want an=7f seg=79", an, seg);
        else n_pass++;
    endtask

    task automatic test_overflow();
        wait_idle("ovf");
        v1 = '0;
        for (int i = 1; i <= 6; i++) begin
            v0 = 32'(i);
            tick();
            if (i == 5) begin
                n_checks++;
                if (Pending !== 3'd4 || Full !== 1'b1 || Overflow !== 1'b0)
                    $display("FAIL ovf_fill pend=%0d full=%b ovf=%b want 4/1/0", Pending, Full, Overflow);
                else n_pass++;
            end
        end
        n_checks++;
        if (Pending !== 3'd4 || Full !== 1'b1)
            $display("FAIL ovf_full pend=%0d full=%b want 4/1", Pending, Full);
        else n_pass++;
        n_checks++;
        if (Overflow !== 1'b1) $display("FAIL ovf_set got=%b want=1", Overflow); else n_pass++;
        ticks(3);
        n_checks++;
        if (Pending !== 3'd4) $display("FAIL ovf_wait pend=%0d want=4", Pending); else n_pass++;
        v0 = 32'h0000_0008;
        tick();
        n_checks++;
        if (Pending !== 3'd4 || Full !== 1'b1)
            $display("FAIL ovf_pushpop pend=%0d full=%b want 4/1", Pending, Full);
        else n_pass++;
        wait_idle("ovf_drain");
        n_checks++;
        if (Overflow !== 1'b1) $display("FAIL ovf_sticky got=%b want=1", Overflow); else n_pass++;
        n_checks++;
        if (Full !== 1'b0) $display("FAIL ovf_unfull got=%b want=0", Full); else n_pass++;
        n_checks++;
        if (dut.hold_q !== 32'h0008_0000)
            $display("FAIL ovf_last got=%h want=%h", dut.hold_q, 32'h0008_0000);
        else n_pass++;
    endtask

    task automatic test_dwell();
        wait_idle("dwell");
        v0 = 32'h0000_0A0A;
        v1 = '0;
        tick();
        v0 = 32'h0000_0B0B;
        v1 = 32'h0000_5678;
        tick();
        n_checks++;
        if (dut.hold_q !== 32'h0A0A_0000)
            $display("FAIL dwell_first got=%h want=%h", dut.hold_q, 32'h0A0A_0000);
        else n_pass++;
        ticks(7);
        n_checks++;
        if (dut.hold_q !== 32'h0A0A_0000)
            $display("FAIL dwell_hold7 got=%h want=%h", dut.hold_q, 32'h0A0A_0000);
        else n_pass++;
        tick();
        n_checks++;
        if (dut.hold_q !== 32'h0B0B_5678)
            $display("FAIL dwell_second got=%h want=%h", dut.hold_q, 32'h0B0B_5678);
        else n_pass++;
        ticks(7);
        n_checks++;
        if (dut.state_q !== 1'b1) $display("FAIL dwell_show got=%b want=1", dut.state_q); else n_pass++;
        tick();
        n_checks++;
        if (dut.state_q !== 1'b0 || dut.hold_q !== 32'h0B0B_5678)
            $display("FAIL dwell_idle state=%b hold=%h want 0/0b0b5678", dut.state_q, dut.hold_q);
        else n_pass++;
    endtask

    task automatic test_blanking();
        logic [6:0] got [8];
        logic [6:0] exp [8];
        bit         seen [8];
        wait_idle("blank");
`ifdef RESULT_BLANK_LEADING_EN
        exp = '{7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h78, 7'h7F, 7'h7F, 7'h7F};
`else
        exp = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h78, 7'h40, 7'h40, 7'h40};
`endif
        for (int d = 0; d < 8; d++) begin
            seen[d] = 1'b0;
            got[d]  = '0;
        end
        v0 = 32'h0000_0007;
        v1 = '0;
        ticks(3);
        for (int t = 0; t < 40; t++) begin
            for (int d = 0; d < 8; d++) begin
                if (an == ~(8'd1 << d)) begin
                    got[d]  = seg;
                    seen[d] = 1'b1;
                end
            end
            tick();
        end
        for (int d = 0; d < 8; d++) begin
            n_checks++;
            if (!seen[d] || got[d] !== exp[d])
                $display("FAIL blank_dig%0d seen=%b got=%h want=%h", d, seen[d], got[d], exp[d]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_show();
        wait_idle("midrst");
        v1 = '0;
        v0 = 32'h0000_0001;
        tick();
        v0 = 32'h0000_0002;
        tick();
        v0 = 32'h0000_0003;
        tick();
        v0 = 32'h0000_00AB;
        tick();
        n_checks++;
        if (Pending !== 3'd3 || dut.state_q !== 1'b1)
            $display("FAIL midrst_pre pend=%0d state=%b want 3/1", Pending, dut.state_q);
        else n_pass++;
        Reset = 1'b0;
        ticks(2);
        n_checks++;
        if (Pending !== 3'd0 || an !== 8'hFF || Overflow !== 1'b0)
            $display("FAIL midrst_in pend=%0d an=%h ovf=%b want 0/ff/0", Pending, an, Overflow);
        else n_pass++;
        Reset = 1'b1;
        tick();
        n_checks++;
        if (Pending !== 3'd1) $display("FAIL midrst_recap got=%0d want=1", Pending); else n_pass++;
        tick();
        n_checks++;
        if (Pending !== 3'd0 || dut.hold_q !== 32'h00AB_0000)
            $display("FAIL midrst_pop pend=%0d hold=%h want 0/00ab0000", Pending, dut.hold_q);
        else n_pass++;
        ticks(8);
        n_checks++;
        if (dut.state_q !== 1'b0 || Pending !== 3'd0 || dut.hold_q !== 32'h00AB_0000)
            $display("FAIL midrst_end state=%b pend=%0d hold=%h want 0/0/00ab0000",
                     dut.state_q, Pending, dut.hold_q);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_dwell();
        test_blanking();
        test_reset_mid_show();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
